// File: rtl/irq_event_ctrl.sv
// -----------------------------------------------------------------------------
// irq_event_ctrl
//
// Interrupt event controller on an Avalon-MM slave port. It collects level
// interrupt lines from timer slaves into per-channel pending bits. Each
// channel is either edge-captured or level-captured. The controller counts
// edge events that arrive while a channel is already pending. It drives one
// registered aggregate interrupt to the CPU.
//
// Register map (word addresses):
//   0 PENDING  R / write-1-to-clear
//   1 MASK     RW
//   2 MODE     RW   (1 = edge, 0 = level)
//   3 ACTIVE   RO   PENDING & MASK
//   4 MISSED   RO   8-bit saturating counter; any write clears it
//   5 RAW      RO   irq_in as seen this cycle
//   6 SWTRIG   write-1-to-set PENDING when IRQ_EVENT_CTRL_SWTRIG_EN is
//                   defined; always reads 0
//   7          reads 0
//
// Optional feature macro: IRQ_EVENT_CTRL_SWTRIG_EN (software trigger register).
//
// Ports:
//   clk         single clock, rising edge
//   reset       synchronous, active-high
//   address     [2:0] word address
//   chipselect  slave select
//   write_n     active-low write strobe
//   writedata   [15:0] write data
//   readdata    [15:0] registered read data, one cycle after address
//   irq_in      [NUM_IRQ-1:0] interrupt lines, same clock domain
//   irq         registered aggregate interrupt
// -----------------------------------------------------------------------------
module irq_event_ctrl #(
    parameter int NUM_IRQ = 4
) (
    input  logic               clk,
    input  logic               reset,
    input  logic [2:0]         address,
    input  logic               chipselect,
    input  logic               write_n,
    input  logic [15:0]        writedata,
    output logic [15:0]        readdata,
    input  logic [NUM_IRQ-1:0] irq_in,
    output logic               irq
);

    logic [NUM_IRQ-1:0] pending_reg, pending_next;
    logic [NUM_IRQ-1:0] pending_base;
    logic [NUM_IRQ-1:0] mask_reg;
    logic [NUM_IRQ-1:0] mode_reg;
    logic [NUM_IRQ-1:0] prev_reg;
    logic [7:0]         missed_reg, missed_next;
    logic [15:0]        readdata_reg, readdata_next;
    logic               irq_reg;

    logic [NUM_IRQ-1:0] edge_det;
    logic [NUM_IRQ-1:0] clr_bits;
    logic [NUM_IRQ-1:0] miss_bits;
    logic               wr_en;
    logic               wr0, wr1, wr2, wr4;

    // Upper writedata bits are only partly decoded for small NUM_IRQ.
    logic               unused_writedata;
    assign unused_writedata = ^writedata;

    assign wr_en = chipselect && !write_n;
    assign wr0   = wr_en && (address == 3'd0);
    assign wr1   = wr_en && (address == 3'd1);
    assign wr2   = wr_en && (address == 3'd2);
    assign wr4   = wr_en && (address == 3'd4);

    assign edge_det = irq_in & ~prev_reg;
    assign clr_bits = wr0 ? writedata[NUM_IRQ-1:0] : '0;

    // Per-channel capture. The set term is ORed in after the clear, so a
    // simultaneous event wins over W1C. In level mode a high input keeps
    // re-setting the bit, which makes W1C effective only once the line drops.
    // MODE is sampled from the register, so a MODE write takes effect one
    // cycle later and leaves existing pending bits untouched.
    generate
        for (genvar gi = 0; gi < NUM_IRQ; gi++) begin : g_chan
            assign pending_base[gi] = (mode_reg[gi] ? edge_det[gi] : irq_in[gi])
                                    | (pending_reg[gi] & ~clr_bits[gi]);
            assign miss_bits[gi]    = mode_reg[gi] & edge_det[gi]
                                    & pending_reg[gi] & ~clr_bits[gi];
        end
    endgenerate

`ifdef IRQ_EVENT_CTRL_SWTRIG_EN
    logic               wr6;
    logic [NUM_IRQ-1:0] sw_set;
    assign wr6          = wr_en && (address == 3'd6);
    assign sw_set       = wr6 ? writedata[NUM_IRQ-1:0] : '0;
    assign pending_next = pending_base | sw_set;
`else
    assign pending_next = pending_base;
`endif

    // A counter clear has priority over a same-cycle increment.
    always_comb begin
        missed_next = missed_reg;
        if (wr4) begin
            missed_next = 8'd0;
        end else if ((|miss_bits) && (missed_reg != 8'hFF)) begin
            missed_next = missed_reg + 8'd1;
        end
    end

    // The read mux runs every cycle whether or not the slave is selected.
    always_comb begin
        readdata_next = '0;
        case (address)
            3'd0: readdata_next[NUM_IRQ-1:0] = pending_reg;
            3'd1: readdata_next[NUM_IRQ-1:0] = mask_reg;
            3'd2: readdata_next[NUM_IRQ-1:0] = mode_reg;
            3'd3: readdata_next[NUM_IRQ-1:0] = pending_reg & mask_reg;
            3'd4: readdata_next[7:0]         = missed_reg;
            3'd5: readdata_next[NUM_IRQ-1:0] = irq_in;
            default: readdata_next = '0;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            pending_reg  <= '0;
            mask_reg     <= '0;
            mode_reg     <= '1;
            prev_reg     <= '0;
            missed_reg   <= 8'd0;
            readdata_reg <= 16'd0;
            irq_reg      <= 1'b0;
        end else begin
            pending_reg  <= pending_next;
            prev_reg     <= irq_in;
            missed_reg   <= missed_next;
            readdata_reg <= readdata_next;
            irq_reg      <= |(pending_reg & mask_reg);
            if (wr1) begin
                mask_reg <= writedata[NUM_IRQ-1:0];
            end
            if (wr2) begin
                mode_reg <= writedata[NUM_IRQ-1:0];
            end
        end
    end

    assign readdata = readdata_reg;
    assign irq      = irq_reg;

endmodule
